pio_cmd_ctrl: RTL and testbench

PIO_CMD_CTRL -- requirements
Module: pio_cmd_ctrl

---
 rtl/pio_cmd_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pio_cmd_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_ctrl.sv
// HPS PIO command controller: four-phase req/ack handshake driving pixel memory and the edge engine.
// Optional PIO_CMD_SYNC_EN: double-flop synchronizer on cmd_i (adds 2 cycles to accept and release).
module pio_cmd_ctrl #(
   parameter int unsigned ADDR_W = 18
) (
   input  logic              clk_clk,
   input  logic              reset,
   input  logic [31:0]       cmd_i,
   output logic [31:0]       sts_o,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              eng_start,
   input  logic              eng_done
);

   localparam int unsigned OP_W    = 3;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PAD_W   = 18;
   localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
   localparam logic [OP_W-1:0] OP_WRITE  = 3'd1;
   localparam logic [OP_W-1:0] OP_READ   = 3'd2;
   localparam logic [OP_W-1:0] OP_START  = 3'd3;
   localparam logic [OP_W-1:0] OP_STATUS = 3'd4;

   typedef enum logic [2:0] {IDLE, EXEC, RD_WAIT, ACK, REL} state_t;

   logic [31:0] cmd;

`ifdef PIO_CMD_SYNC_EN
   logic [31:0] cmd_meta;
   logic [31:0] cmd_sync;

   always_ff @(posedge clk_clk) begin
      if (reset) begin
         cmd_meta <= '0;
         cmd_sync <= '0;
      end else begin
         cmd_meta <= cmd_i;
         cmd_sync <= cmd_meta;
      end
   end

   assign cmd = cmd_sync;
`else
   assign cmd = cmd_i;
`endif

   logic              req;
   logic [OP_W-1:0]   op_in;
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] wdata_in;
   logic              unused_addr_hi;

   assign req      = cmd[31];
   assign op_in    = cmd[30:28];
   assign addr_in  = cmd[8 +: ADDR_W];
   assign wdata_in = cmd[7:0];
   // address bits above ADDR_W are ignored by design
   assign unused_addr_hi = ^(cmd[27:8] >> ADDR_W);

   state_t            state, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [OP_W-1:0]   last_op, last_op_d;
   logic              ack, ack_d;
   logic              err, err_d;
   logic              busy, busy_d;
   logic [DATA_W-1:0] rdata, rdata_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              we_d, re_d, start_d;

   always_ff @(posedge clk_clk) begin
      if (reset) begin
         state     <= IDLE;
         op_q      <= '0;
         last_op   <= '0;
         ack       <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         eng_start <= 1'b0;
      end else begin
         state     <= state_d;
         op_q      <= op_d;
         last_op   <= last_op_d;
         ack       <= ack_d;
         err       <= err_d;
         busy      <= busy_d;
         rdata     <= rdata_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         mem_we    <= we_d;
         mem_re    <= re_d;
         eng_start <= start_d;
      end
   end

   // Strobes are registered on the accepting edge so they are high exactly during EXEC.
   always_comb begin
      state_d   = state;
      op_d      = op_q;
      last_op_d = last_op;
      ack_d     = ack;
      err_d     = err;
      busy_d    = busy & ~eng_done;
      rdata_d   = rdata;
      addr_d    = mem_addr;
      wdata_d   = mem_wdata;
      we_d      = 1'b0;
      re_d      = 1'b0;
      start_d   = 1'b0;

      case (state)
         IDLE: begin
            if (req) begin
               state_d = EXEC;
               op_d    = op_in;
               addr_d  = addr_in;
               wdata_d = wdata_in;
               err_d   = 1'b0;
               case (op_in)
                  OP_WRITE: we_d = 1'b1;
                  OP_READ:  re_d = 1'b1;
                  OP_START: begin
                     // a coincident eng_done frees the engine for this START
                     if (busy & ~eng_done) begin
                        err_d = 1'b1;
                     end else begin
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                     end
                  end
                  OP_NOP, OP_STATUS: ;
                  default: err_d = 1'b1;
               endcase
            end
         end
         EXEC:    state_d = (op_q == OP_READ) ? RD_WAIT : ACK;
         RD_WAIT: begin
            rdata_d = mem_rdata;
            state_d = ACK;
         end
         ACK: begin
            ack_d     = 1'b1;
            last_op_d = op_q;
            state_d   = REL;
         end
         REL: begin
            if (!req) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sts_o = {ack, err, busy, last_op, PAD_W'(0), rdata};

endmodule

// File: tb/tb_pio_cmd_ctrl.sv
// Bench for pio_cmd_ctrl: directed handshake cases plus random commands against a command-level model.
module tb_pio_cmd_ctrl;

   localparam int unsigned ADDR_W = 18;
`ifdef PIO_CMD_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic              clk_clk = 1'b0;
   logic              reset = 1'b1;
   logic [31:0]       cmd_i = '0;
   logic [31:0]       sts_o;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [7:0]        mem_rdata = '0;
   logic              eng_start;
   logic              eng_done = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk_clk = ~clk_clk;

   pio_cmd_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk_clk   (clk_clk),
      .reset     (reset),
      .cmd_i     (cmd_i),
      .sts_o     (sts_o),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .eng_start (eng_start),
      .eng_done  (eng_done)
   );

   // pixel memory with one-cycle read latency
   logic [7:0] bmem [int];
   always @(posedge clk_clk) begin
      if (mem_we) bmem[int'(mem_addr)] = mem_wdata;
      if (mem_re) mem_rdata <= bmem.exists(int'(mem_addr)) ? bmem[int'(mem_addr)] : 8'h00;
   end

   // strobe monitor: cycles high, last addresses seen, overlap count
   int we_cyc = 0, re_cyc = 0, st_cyc = 0, mutex_bad = 0;
   int we_addr = 0, re_addr = 0;
   logic [7:0] we_data = '0;
   always @(posedge clk_clk) begin
      if (mem_we) begin we_cyc++; we_addr = int'(mem_addr); we_data = mem_wdata; end
      if (mem_re) begin re_cyc++; re_addr = int'(mem_addr); end
      if (eng_start) st_cyc++;
      if (int'(mem_we) + int'(mem_re) + int'(eng_start) > 1) mutex_bad++;
   end

   // command-level model of the status word
   bit         m_busy = 0, m_err = 0;
   logic [2:0] m_op = '0;
   logic [7:0] m_rdata = '0;
   logic [7:0] m_mem [int];

   function automatic logic [31:0] exp_sts(input bit ack);
      return {ack, m_err, m_busy, m_op, 18'd0, m_rdata};
   endfunction

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Assumes cmd already sits on cmd_i; runs the handshake to completion and checks it.
   task automatic run_cmd(input logic [31:0] cmd, input bit done_at_accept, input int hold);
      int         n, a, lat, w0, r0, s0;
      logic [2:0] op;
      logic [7:0] d;
      bit         ew, er, es;
      op = cmd[30:28];
      a  = int'(cmd[27:8]) % (1 << ADDR_W);
      d  = cmd[7:0];
      ew = 0; er = 0; es = 0;
      w0 = we_cyc; r0 = re_cyc; s0 = st_cyc;
      if (done_at_accept) m_busy = 0;
      m_err = 0;
      case (op)
         3'd1: begin ew = 1; m_mem[a] = d; end
         3'd2: begin er = 1; m_rdata = m_mem.exists(a) ? m_mem[a] : 8'h00; end
         3'd3: if (m_busy) m_err = 1; else begin es = 1; m_busy = 1; end
         3'd0, 3'd4: ;
         default: m_err = 1;
      endcase
      m_op = op;
      lat  = (op == 3'd2) ? 3 : 2;

      n = 0;
      while (sts_o[31] !== 1'b1 && n < 30) begin
         eng_done = done_at_accept && (n == SL);
         tick();
         eng_done = 1'b0;
         n++;
      end
      check($sformatf("ack_latency op%0d", op), n, SL + lat + 1);
      check($sformatf("sts_at_ack op%0d", op), sts_o, exp_sts(1));

      for (int i = 0; i < hold; i++) begin
         cmd_i = {1'b1, 31'($urandom)};
         tick();
      end
      if (hold > 0) check("sts_while_held", sts_o, exp_sts(1));

      cmd_i = {1'b0, 31'($urandom)};
      n = 0;
      while (sts_o[31] !== 1'b0 && n < 30) begin
         tick();
         n++;
      end
      check("release_latency", n, SL + 1);
      check("sts_after_release", sts_o, exp_sts(0));

      check("we_cycles", we_cyc - w0, 32'(ew));
      check("re_cycles", re_cyc - r0, 32'(er));
      check("start_cycles", st_cyc - s0, 32'(es));
      if (ew) begin
         check("we_addr", we_addr, a);
         check("we_data", 32'(we_data), 32'(d));
      end
      if (er) check("re_addr", re_addr, a);
      check("strobe_overlap", mutex_bad, 0);
   endtask

   task automatic do_cmd(input logic [31:0] cmd, input bit done_at_accept, input int hold);
      cmd_i = cmd;
      run_cmd(cmd, done_at_accept, hold);
   endtask

   task automatic pulse_done();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      m_busy = 0;
      check("sts_after_done", sts_o, exp_sts(0));
   endtask

   initial begin
      logic [31:0] rc;
      logic [2:0]  rop;

      // reset state
      tick();
      tick();
      check("reset_sts", sts_o, 32'h0);
      check("reset_addr", 32'(mem_addr), 32'h0);
      check("reset_wdata", 32'(mem_wdata), 32'h0);
      check("reset_strobes", {29'd0, mem_we, mem_re, eng_start}, 32'h0);
      reset = 1'b0;
      tick();

      // write, then read of a preloaded location
      do_cmd(32'h9001_2345, 0, 2);
      check("write_ack_word", {sts_o[31:26], 26'd0} | 32'h8400_0000, 32'h0400_0000 | {1'b1, 31'd0});
      bmem[32'h10]   = 8'hA5;
      m_mem[32'h10]  = 8'hA5;
      do_cmd(32'hA000_1000, 0, 0);

      // START twice, engine completion, START coinciding with eng_done
      do_cmd(32'hB000_0000, 0, 0);
      do_cmd(32'hB000_0000, 0, 1);
      pulse_done();
      do_cmd(32'hB000_0000, 0, 0);
      do_cmd(32'hB000_0000, 1, 0);
      pulse_done();

      // illegal opcode then NOP clears err
      do_cmd(32'hF000_0000, 0, 0);
      do_cmd(32'h8000_0000, 0, 0);

      // reset while waiting for read data, req held through reset
      cmd_i = 32'hA000_1000;
      for (int i = 0; i < SL + 2; i++) tick();
      reset = 1'b1;
      tick();
      check("abort_sts", sts_o, 32'h0);
      check("abort_strobes", {29'd0, mem_we, mem_re, eng_start}, 32'h0);
      check("abort_addr", 32'(mem_addr), 32'h0);
      m_busy = 0; m_err = 0; m_op = '0; m_rdata = '0;
      reset = 1'b0;
      run_cmd(32'hA000_1000, 0, 0);

      // random commands with random engine completions and hold times
      for (int k = 0; k < 40; k++) begin
         rop = 3'($urandom_range(0, 7));
         rc  = {1'b1, rop, 2'($urandom_range(0, 3)), 14'd0, 4'($urandom_range(0, 15)), 8'($urandom)};
         if ($urandom_range(0, 2) == 0) pulse_done();
         do_cmd(rc, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
